// File: rtl/multicycle_alu.sv
// ---------------------------------------------------------------------------
// multicycle_alu
//   Handshaked ALU. Logic, shift, compare, add/sub and the reserved opcodes
//   complete in one cycle. MUL (and, when built with the divider, DIVU/REMU)
//   iterate one operand bit per cycle for DATA_WIDTH cycles.
//
//   Build option: define MULTICYCLE_ALU_DIV_EN to include the restoring
//   divider for opcodes 11 (DIVU) and 12 (REMU). If the macro is not
//   defined, these opcodes complete in one cycle with result 0.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous, active-high reset
//   in_valid   in   operands/opcode valid
//   in_ready   out  operation accepted this cycle (state == IDLE)
//   ALUop1/2   in   operands, DATA_WIDTH bits
//   ALUctrl    in   4-bit opcode
//   out_valid  out  ALUout/EQ hold a result (state == DONE)
//   out_ready  in   consumer takes the result (only looked at in DONE)
//   ALUout     out  registered result
//   EQ         out  registered flag, captured ALUop1 == ALUop2
// ---------------------------------------------------------------------------
module multicycle_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] ALUop1,
  input  logic [DATA_WIDTH-1:0] ALUop2,
  input  logic [3:0]            ALUctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUout,
  output logic                  EQ
);

  localparam int SW = $clog2(DATA_WIDTH);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
`ifdef MULTICYCLE_ALU_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q;
  logic [3:0]            op_q;
  // Shared iteration registers:
  //   MUL : acc = partial product, opa = multiplicand (<<), opb = multiplier (>>)
  //   DIV : acc = remainder,       opa = dividend -> quotient, opb = divisor
  logic [DATA_WIDTH-1:0] acc_q, opa_q, opb_q;
  logic [DATA_WIDTH-1:0] acc_step, opa_step, opb_step;
  logic [DATA_WIDTH-1:0] iter_result;
  logic                  eq_pend_q;
  logic [DATA_WIDTH-1:0] alu_out_q;
  logic                  eq_q;

  logic                  is_multi;
  logic [SW-1:0]         shamt;
  logic [DATA_WIDTH-1:0] quick_result;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign ALUout    = alu_out_q;
  assign EQ        = eq_q;

`ifdef MULTICYCLE_ALU_DIV_EN
  assign is_multi = (ALUctrl == OP_MUL) || (ALUctrl == OP_DIVU) || (ALUctrl == OP_REMU);
`else
  assign is_multi = (ALUctrl == OP_MUL);
`endif

  // Only the low log2(DATA_WIDTH) bits of op2 select the shift distance.
  assign shamt = ALUop2[SW-1:0];

  // Single-cycle datapath, evaluated on the live inputs in the accept cycle.
  always_comb begin
    quick_result = '0;
    case (ALUctrl)
      OP_ADD:  quick_result = ALUop1 + ALUop2;
      OP_SUB:  quick_result = ALUop1 - ALUop2;
      OP_AND:  quick_result = ALUop1 & ALUop2;
      OP_OR:   quick_result = ALUop1 | ALUop2;
      OP_XOR:  quick_result = ALUop1 ^ ALUop2;
      OP_SLT:  quick_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(ALUop1) < $signed(ALUop2))};
      OP_SLTU: quick_result = {{(DATA_WIDTH-1){1'b0}}, (ALUop1 < ALUop2)};
      OP_SLL:  quick_result = ALUop1 << shamt;
      OP_SRL:  quick_result = ALUop1 >> shamt;
      OP_SRA:  quick_result = $unsigned($signed(ALUop1) >>> shamt);
      default: quick_result = '0;
    endcase
  end

`ifdef MULTICYCLE_ALU_DIV_EN
  // Partial remainder with the next dividend bit shifted in. One extra bit
  // so the compare against the divisor is exact.
  logic [DATA_WIDTH:0] rem_shift;
  assign rem_shift = {acc_q, opa_q[DATA_WIDTH-1]};
`endif

  // One iteration step of the active multi-cycle operation.
  always_comb begin
    acc_step = acc_q;
    opa_step = opa_q;
    opb_step = opb_q;
    if (op_q == OP_MUL) begin
      if (opb_q[0]) begin
        acc_step = acc_q + opa_q;
      end
      opa_step = opa_q << 1;
      opb_step = opb_q >> 1;
    end
`ifdef MULTICYCLE_ALU_DIV_EN
    else begin
      // Restoring step. A zero divisor always "fits", which naturally yields
      // an all-ones quotient and leaves the dividend as the remainder.
      opa_step = {opa_q[DATA_WIDTH-2:0], 1'b0};
      if (rem_shift >= {1'b0, opb_q}) begin
        // True difference is < divisor, so W-bit arithmetic is exact.
        acc_step    = rem_shift[DATA_WIDTH-1:0] - opb_q;
        opa_step[0] = 1'b1;
      end else begin
        acc_step = rem_shift[DATA_WIDTH-1:0];
      end
    end
`endif
  end

  always_comb begin
    iter_result = acc_step;
`ifdef MULTICYCLE_ALU_DIV_EN
    if (op_q == OP_DIVU) begin
      iter_result = opa_step;
    end
`endif
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = is_multi ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      eq_pend_q <= 1'b0;
      alu_out_q <= '0;
      eq_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q <= ALUctrl;
            if (is_multi) begin
              acc_q     <= '0;
              opa_q     <= ALUop1;
              opb_q     <= ALUop2;
              cnt_q     <= CW'(DATA_WIDTH);
              eq_pend_q <= (ALUop1 == ALUop2);
            end else begin
              // Single-cycle ops enter DONE at this edge.
              alu_out_q <= quick_result;
              eq_q      <= (ALUop1 == ALUop2);
            end
          end
        end
        BUSY: begin
          acc_q <= acc_step;
          opa_q <= opa_step;
          opb_q <= opb_step;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            // Final step: publish result together with the DONE transition.
            alu_out_q <= iter_result;
            eq_q      <= eq_pend_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  ALUop1;
  logic [W-1:0]  ALUop2;
  logic [3:0]    ALUctrl;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  ALUout;
  logic          EQ;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_alu #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUop1    (ALUop1),
    .ALUop2    (ALUop2),
    .ALUctrl   (ALUctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUout    (ALUout),
    .EQ        (EQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        eq;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input logic eq, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.eq = eq; v.lat = lat;
    return v;
  endfunction

  // Issue one operation with out_ready=1, measure accept->out_valid latency,
  // check result, flag, in_ready during execution and return to IDLE.
  task automatic run_op(input string nm, input vec_t v);
    int lat;
    logic busy_ok;
    @(negedge clk);
    chk({nm, " in_ready_pre"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    ALUctrl   = v.op;
    ALUop1    = v.a;
    ALUop2    = v.b;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    ALUop1   = 32'hDEADBEEF;   // inputs after accept must not matter
    ALUop2   = 32'h0BADF00D;
    lat      = 1;
    busy_ok  = 1'b1;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(v.lat));
    chk({nm, " ALUout"}, ALUout, v.res);
    chk({nm, " EQ"}, 32'(EQ), 32'(v.eq));
    chk({nm, " in_ready_busy"}, 32'(busy_ok), 32'd1);
    @(negedge clk);
    chk({nm, " in_ready_post"}, 32'(in_ready), 32'd1);
    $display("op=%0d a=%h b=%h -> ALUout=%h EQ=%0b lat=%0d", v.op, v.a, v.b, ALUout, EQ, lat);
  endtask

  initial begin
    int lat;
    logic stable_ok;
    logic quiet_ok;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ALUop1 = '0; ALUop2 = '0; ALUctrl = '0;

    // Vector table
    vecs.push_back(mk(4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1));
    vecs.push_back(mk(4'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1));
    vecs.push_back(mk(4'd1,  32'h00000010, 32'h00000010, 32'h00000000, 1'b1, 1));
    vecs.push_back(mk(4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1));
    vecs.push_back(mk(4'd3,  32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1));
    vecs.push_back(mk(4'd4,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1));
    vecs.push_back(mk(4'd5,  32'hFFFFFFFE, 32'h00000001, 32'h00000001, 1'b0, 1));
    vecs.push_back(mk(4'd6,  32'hFFFFFFFE, 32'h00000001, 32'h00000000, 1'b0, 1));
    vecs.push_back(mk(4'd7,  32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1));
    vecs.push_back(mk(4'd8,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1));
    vecs.push_back(mk(4'd9,  32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1));
    vecs.push_back(mk(4'd9,  32'h40000000, 32'h0000001F, 32'h00000000, 1'b0, 1));
    vecs.push_back(mk(4'd10, 32'h00012345, 32'h00000010, 32'h00123450, 1'b0, 33));
    vecs.push_back(mk(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1, 33));
    vecs.push_back(mk(4'd13, 32'h12345678, 32'h00000001, 32'h00000000, 1'b0, 1));
    vecs.push_back(mk(4'd15, 32'h00000042, 32'h00000042, 32'h00000000, 1'b1, 1));
`ifdef MULTICYCLE_ALU_DIV_EN
    vecs.push_back(mk(4'd11, 32'd100,      32'd7,        32'd14,       1'b0, 33));
    vecs.push_back(mk(4'd12, 32'd100,      32'd7,        32'd2,        1'b0, 33));
    vecs.push_back(mk(4'd11, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 33));
    vecs.push_back(mk(4'd12, 32'd5,        32'd0,        32'd5,        1'b0, 33));
    vecs.push_back(mk(4'd11, 32'hFFFFFFFF, 32'd3,        32'h55555555, 1'b0, 33));
`else
    vecs.push_back(mk(4'd11, 32'd100,      32'd7,        32'd0,        1'b0, 1));
    vecs.push_back(mk(4'd12, 32'd100,      32'd7,        32'd0,        1'b0, 1));
`endif

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset ALUout", ALUout, 32'd0);
    chk("reset EQ", 32'(EQ), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Backpressure: hold out_ready low 10 cycles in DONE
    @(negedge clk);
    in_valid = 1'b1; ALUctrl = 4'd0; ALUop1 = 32'h11; ALUop2 = 32'h22; out_ready = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("stall latency", 32'(lat), 32'd1);
    // Keep presenting a different operation; it must be ignored.
    ALUctrl = 4'd2; ALUop1 = 32'h5; ALUop2 = 32'h5;
    stable_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (ALUout !== 32'h33 || EQ !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1)
        stable_ok = 1'b0;
      @(negedge clk);
    end
    chk("stall hold", 32'(stable_ok), 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall release in_ready", 32'(in_ready), 32'd1);
    chk("stall release out_valid", 32'(out_valid), 32'd0);
    chk("stall ignored op", ALUout, 32'h33);
    $display("stall: ALUout=%h held 10 cycles, in_ready=%0b after release", ALUout, in_ready);

    // Reset in the 5th cycle of a MUL
    @(negedge clk);
    in_valid = 1'b1; ALUctrl = 4'd10; ALUop1 = 32'd3; ALUop2 = 32'd5; out_ready = 1'b1;
    @(negedge clk);            // BUSY cycle 1
    in_valid = 1'b0;
    repeat (4) @(negedge clk); // BUSY cycle 5
    chk("mul busy in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort ALUout", ALUout, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort in_ready", 32'(in_ready), 32'd1);
    quiet_ok = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (out_valid !== 1'b0) quiet_ok = 1'b0;
      @(negedge clk);
    end
    chk("abort no result", 32'(quiet_ok), 32'd1);
    $display("reset abort: out_valid=%0b ALUout=%h in_ready=%0b", out_valid, ALUout, in_ready);
    run_op("post-reset add", mk(4'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the operand and result width (legal: 8..64, even).
REQ-002 The block SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid  input  1  the operands and opcode are valid.
REQ-005 The block SHALL have port in_ready  output  1  the block accepts an operation this cycle.
REQ-006 The block SHALL have ports ALUop1 and ALUop2  input  DATA_WIDTH  operands.
REQ-007 The block SHALL have port ALUctrl  input  4  opcode.
REQ-008 The block SHALL have port out_valid  output  1  ALUout and EQ hold a result.
REQ-009 The block SHALL have port out_ready  input  1  the consumer takes the result this cycle.
REQ-010 The block SHALL have port ALUout  output  DATA_WIDTH  registered result.
REQ-011 The block SHALL have port EQ  output  1  registered flag, 1 when the captured ALUop1 == ALUop2.

Function
REQ-012 The FSM SHALL have three states: IDLE, BUSY, DONE. in_ready = (state == IDLE).
REQ-013 An operation SHALL be accepted when in_valid && in_ready; the operands and opcode are captured in that cycle, and the inputs are ignored until the FSM returns to IDLE.
REQ-014 Opcodes SHALL be 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed, result 1/0), 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MUL (low DATA_WIDTH bits), 11 DIVU, 12 REMU. Opcodes 13-15 SHALL produce result 0.
REQ-015 The shift amount SHALL be ALUop2[$clog2(DATA_WIDTH)-1:0]. The upper bits SHALL be ignored.
REQ-016 ADD and SUB SHALL wrap modulo 2^DATA_WIDTH, with no overflow flag.
REQ-017 Single-cycle opcodes (0-9, 13-15) SHALL go IDLE->DONE. out_valid SHALL rise in the cycle after acceptance.
REQ-018 MUL SHALL be an iterative shift-add, one operand bit per cycle. It SHALL go IDLE->BUSY, stay in BUSY for exactly DATA_WIDTH cycles (down-counter), then go to DONE. out_valid SHALL rise DATA_WIDTH+1 cycles after acceptance.
REQ-019 DIVU and REMU SHALL use an iterative restoring divide with the same latency as MUL.
REQ-020 Division by zero SHALL give DIVU = all ones and REMU = ALUop1, with the same latency as a normal divide.
REQ-021 In DONE, out_valid SHALL be 1, and ALUout and EQ SHALL be held stable until out_ready.
REQ-022 When out_valid && out_ready, the FSM SHALL go DONE->IDLE in the next cycle. A new operation SHALL NOT be accepted in the handshake cycle, so the minimum issue interval is 2 cycles.
REQ-023 out_ready SHALL be ignored outside DONE. in_valid SHALL be ignored outside IDLE.
REQ-024 ALUout and EQ SHALL change only on entry to DONE.

Reset
REQ-025 When rst is high at a clock edge, the FSM SHALL go to IDLE and the following SHALL be cleared to 0: out_valid, ALUout, EQ, the iteration counter and the internal accumulators.
REQ-026 A reset during BUSY or DONE SHALL abort the operation with no result delivered. in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-027 When macro MULTICYCLE_ALU_DIV_EN is defined, the divider SHALL be compiled in and opcodes 11 and 12 SHALL behave as in REQ-019 and REQ-020.
REQ-028 When MULTICYCLE_ALU_DIV_EN is undefined, there SHALL be no divider logic. Opcodes 11 and 12 SHALL then be single-cycle with result 0.

Verification
REQ-029 The bench SHALL cover: ADD 0xFFFFFFFF + 0x00000001 (DATA_WIDTH=32), out_ready=1 -> out_valid one cycle after accept, ALUout = 0x00000000, EQ = 0.
REQ-030 The bench SHALL cover: SLT 0xFFFFFFFE vs 0x00000001 -> 1; SLTU with the same operands -> 0; SRA 0x80000000 by 0x24 (shift 4) -> 0xF8000000.
REQ-031 The bench SHALL cover: MUL 0x00012345 x 0x00000010 -> 0x00123450 exactly 33 cycles after accept, with in_ready = 0 throughout.
REQ-032 The bench SHALL cover, with MULTICYCLE_ALU_DIV_EN defined: DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
REQ-033 The bench SHALL cover: out_ready held at 0 for 10 cycles in DONE -> ALUout and EQ stable, in_ready = 0, and a new in_valid ignored; after out_ready=1, in_ready = 1 in the next cycle.
REQ-034 The bench SHALL cover: rst asserted in the 5th cycle of a MUL -> next cycle out_valid = 0, ALUout = 0; after rst deasserts, in_ready = 1 and an ADD 2+3 returns 5.
